// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 core.
// Holds the IFU boot address, NOP encoding and fetch FSM states.
package jedro_1_defines;

    localparam logic [31:0] BOOT_ADDR_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

    typedef enum logic {
        IFU_IDLE = 1'b0,
        IFU_RUN  = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } ifu_entry_t;

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// Prefetch buffer for the jedro_1 fetch unit.
// Power-of-two circular buffer with a synchronous flush.
module jedro_1_ifu_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign count_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full    = (count_o == (AW+1)'(DEPTH));
    assign do_push = push_i && !full && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign data_o  = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= data_i;
        end
    end

    // Flush has priority over a same-cycle push, which kills that response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit.
// Credit-limited prefetch into a FIFO, with redirect and flush.
module jedro_1_ifu
    import jedro_1_defines::*;
#(
    parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        imem_en_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_addr_i,
    output logic [31:0] instr_o,
    output logic [31:0] addr_o,
    output logic        valid_o,
    input  logic        ready_i
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    ifu_state_e  state_q;
    logic [31:0] pc_q;
    logic        inflight_q;
    logic [31:0] resp_addr_q;

    logic        run;
    logic        redirect;
    logic [31:0] jmp_tgt;
    logic [AW:0] fifo_count;
    logic [AW+1:0] used;
    logic        credit_ok;
    logic        fifo_empty;
    logic [63:0] fifo_dout;
    ifu_entry_t  head;
    ifu_entry_t  resp;

    assign run      = (state_q == IFU_RUN);
    assign redirect = run && jmp_i;
    assign jmp_tgt  = {jmp_addr_i[31:2], 2'b00};

    // Reads in flight hold a reserved FIFO slot until they land.
    assign used      = {1'b0, fifo_count} + {{(AW+1){1'b0}}, inflight_q};
    assign credit_ok = used < (AW+2)'(FIFO_DEPTH);

    assign imem_en_o   = redirect || (run && credit_ok);
    assign imem_addr_o = redirect ? jmp_tgt : pc_q;

    assign resp.addr  = resp_addr_q;
    assign resp.instr = imem_data_i;
    assign head       = fifo_dout;

    assign valid_o = !fifo_empty;
    assign instr_o = fifo_empty ? 32'h0 : head.instr;
    assign addr_o  = fifo_empty ? 32'h0 : head.addr;

    jedro_1_ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (redirect),
        .push_i  (inflight_q),
        .data_i  (resp),
        .pop_i   (valid_o && ready_i),
        .data_o  (fifo_dout),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IFU_IDLE;
            pc_q        <= BOOT_ADDR;
            inflight_q  <= 1'b0;
            resp_addr_q <= 32'h0;
        end else begin
            unique case (state_q)
                IFU_IDLE: state_q <= IFU_RUN;
                IFU_RUN:  state_q <= IFU_RUN;
                default:  state_q <= IFU_IDLE;
            endcase
            inflight_q <= imem_en_o;
            if (imem_en_o) begin
                resp_addr_q <= imem_addr_o;
            end
            if (redirect) begin
                pc_q <= jmp_tgt + 32'd4;
            end else if (imem_en_o) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Self-checking bench for jedro_1_ifu.
// ROM word n holds n; a cycle-level credit model checks every cycle.
module tb_jedro_1_ifu;

    localparam logic [31:0] BOOT  = 32'h0000_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        imem_en_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i = 32'h0;
    logic        jmp_i = 1'b0;
    logic [31:0] jmp_addr_i = 32'h0;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        valid_o;
    logic        ready_i = 1'b0;

    int checks = 0;
    int errors = 0;

    jedro_1_ifu #(
        .BOOT_ADDR  (BOOT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .imem_en_o   (imem_en_o),
        .imem_addr_o (imem_addr_o),
        .imem_data_i (imem_data_i),
        .jmp_i       (jmp_i),
        .jmp_addr_i  (jmp_addr_i),
        .instr_o     (instr_o),
        .addr_o      (addr_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    always #5 clk = ~clk;

    // ROM: word n = n, one-cycle read latency, garbage when not enabled
    always @(posedge clk) begin
        if (imem_en_o) imem_data_i <= imem_addr_o >> 2;
        else           imem_data_i <= 32'hdead_beef;
    end

    // Reference model: pend = reads issued and neither delivered nor flushed
    int          sb_pend = 0;
    bit          sb_run = 0;
    bit          sb_en_prev = 0;
    logic [31:0] sb_exp = BOOT;
    logic [31:0] sb_fpc = BOOT;

    always @(negedge clk) begin
        if (!rstn_i) begin
            sb_run = 0; sb_pend = 0; sb_en_prev = 0;
            sb_exp = BOOT; sb_fpc = BOOT;
            checks++;
            if (valid_o !== 1'b0 || imem_en_o !== 1'b0 || imem_addr_o !== BOOT
                || instr_o !== 32'h0 || addr_o !== 32'h0) begin
                errors++;
                $display("FAIL sb_reset: valid=%b en=%b iaddr=%h instr=%h addr=%h required 0 0 %h 0 0",
                         valid_o, imem_en_o, imem_addr_o, instr_o, addr_o, BOOT);
            end
        end else if (!sb_run) begin
            checks++;
            if (imem_en_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL sb_idle: en=%b valid=%b required 0 0", imem_en_o, valid_o);
            end
            sb_run = 1;
            sb_en_prev = 0;
        end else begin
            logic        exp_valid;
            logic        exp_en;
            logic [31:0] tgt;
            logic [31:0] exp_iaddr;
            tgt = {jmp_addr_i[31:2], 2'b00};
            exp_valid = (sb_pend - int'(sb_en_prev)) > 0;
            exp_en = jmp_i || (sb_pend < DEPTH);
            exp_iaddr = jmp_i ? tgt : sb_fpc;
            checks++;
            if (valid_o !== exp_valid) begin
                errors++;
                $display("FAIL sb_valid: got %b required %b", valid_o, exp_valid);
            end
            if (exp_valid && valid_o === 1'b1) begin
                checks++;
                if (addr_o !== sb_exp || instr_o !== (sb_exp >> 2)) begin
                    errors++;
                    $display("FAIL sb_data: addr=%h instr=%h required %h %h",
                             addr_o, instr_o, sb_exp, sb_exp >> 2);
                end
            end
            checks++;
            if (imem_en_o !== exp_en) begin
                errors++;
                $display("FAIL sb_en: got %b required %b", imem_en_o, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (imem_addr_o !== exp_iaddr) begin
                    errors++;
                    $display("FAIL sb_iaddr: got %h required %h", imem_addr_o, exp_iaddr);
                end
            end
            if (exp_valid && ready_i) begin
                sb_pend--;
                sb_exp = sb_exp + 32'd4;
            end
            if (jmp_i) begin
                sb_pend = 0;
                sb_exp = tgt;
                sb_fpc = tgt;
            end
            if (exp_en) begin
                sb_pend++;
                sb_fpc = sb_fpc + 32'd4;
            end
            sb_en_prev = exp_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        jmp_i = 1'b0;
        tick();
        tick();
        rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        ready_i = 1'b1;
        jmp_i = 1'b1;
        jmp_addr_i = 32'h0000_0100;
        tick();
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || imem_en_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: valid=%b en=%b required 0 0", valid_o, imem_en_o);
        end
        checks++;
        if (imem_addr_o !== BOOT) begin
            errors++;
            $display("FAIL reset_iaddr: got %h required %h", imem_addr_o, BOOT);
        end
        checks++;
        if (instr_o !== 32'h0 || addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: instr=%h addr=%h required 0 0", instr_o, addr_o);
        end
        jmp_i = 1'b0;
        tick();
    endtask

    task automatic test_boot();
        logic        en [7];
        logic [31:0] ia [7];
        logic        vl [7];
        logic [31:0] ad [7];
        logic [31:0] in [7];
        ready_i = 1'b1;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            en[k] = imem_en_o; ia[k] = imem_addr_o;
            vl[k] = valid_o; ad[k] = addr_o; in[k] = instr_o;
            tick();
        end
        checks++;
        if (en[0] !== 1'b0 || en[1] !== 1'b1 || ia[1] !== 32'h0) begin
            errors++;
            $display("FAIL boot_en: en0=%b en1=%b ia1=%h required 0 1 0", en[0], en[1], ia[1]);
        end
        checks++;
        if (vl[1] !== 1'b0 || vl[2] !== 1'b0 || vl[3] !== 1'b1) begin
            errors++;
            $display("FAIL boot_lat: v1=%b v2=%b v3=%b required 0 0 1", vl[1], vl[2], vl[3]);
        end
        for (int k = 3; k < 7; k++) begin
            checks++;
            if (vl[k] !== 1'b1 || ad[k] !== 32'((k-3)*4) || in[k] !== 32'(k-3)) begin
                errors++;
                $display("FAIL boot_seq%0d: v=%b addr=%h instr=%h required 1 %h %h",
                         k, vl[k], ad[k], in[k], 32'((k-3)*4), 32'(k-3));
            end
        end
    endtask

    task automatic test_stall();
        int          nreads = 0;
        logic [31:0] reads [$];
        logic [31:0] hold_a;
        logic [31:0] got [$];
        logic [31:0] first_ia = 32'hffff_ffff;
        bit          seen_en = 0;
        ready_i = 1'b0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (imem_en_o) begin
                nreads++;
                reads.push_back(imem_addr_o);
            end
            if (k == 8) hold_a = addr_o;
            tick();
        end
        checks++;
        if (nreads != 4) begin
            errors++;
            $display("FAIL stall_nreads: got %0d required 4", nreads);
        end
        for (int i = 0; i < 4 && i < reads.size(); i++) begin
            checks++;
            if (reads[i] !== 32'(i*4)) begin
                errors++;
                $display("FAIL stall_raddr%0d: got %h required %h", i, reads[i], 32'(i*4));
            end
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || addr_o !== 32'h0 || addr_o !== hold_a || instr_o !== 32'h0) begin
            errors++;
            $display("FAIL stall_hold: valid=%b addr=%h earlier=%h instr=%h required 1 0 0 0",
                     valid_o, addr_o, hold_a, instr_o);
        end
        tick();
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (valid_o) got.push_back(addr_o);
            if (imem_en_o && !seen_en) begin
                seen_en = 1;
                first_ia = imem_addr_o;
            end
            tick();
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL stall_drain_n: got %0d required 4", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== 32'(i*4)) begin
                errors++;
                $display("FAIL stall_drain%0d: got %h required %h", i, got[i], 32'(i*4));
            end
        end
        checks++;
        if (first_ia !== 32'h10) begin
            errors++;
            $display("FAIL stall_resume: got %h required 00000010", first_ia);
        end
    endtask

    task automatic test_jump();
        ready_i = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        jmp_i = 1'b1;
        jmp_addr_i = 32'h40;
        ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_en_o !== 1'b1 || imem_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL jump_issue: en=%b iaddr=%h required 1 00000040", imem_en_o, imem_addr_o);
        end
        tick();
        jmp_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL jump_t1: valid=%b addr=%h required 0", valid_o, addr_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || addr_o !== 32'h40 || instr_o !== 32'h10) begin
            errors++;
            $display("FAIL jump_t2: valid=%b addr=%h instr=%h required 1 00000040 00000010",
                     valid_o, addr_o, instr_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || addr_o !== 32'h44) begin
            errors++;
            $display("FAIL jump_t3: valid=%b addr=%h required 1 00000044", valid_o, addr_o);
        end
        tick();
    endtask

    task automatic test_double_jump();
        int          first_k = -1;
        logic [31:0] first_a = 32'hffff_ffff;
        bit          seen40 = 0;
        ready_i = 1'b1;
        do_reset();
        for (int k = 0; k < 8; k++) tick();
        jmp_i = 1'b1;
        jmp_addr_i = 32'h40;
        tick();
        jmp_addr_i = 32'h80;
        tick();
        jmp_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (valid_o && addr_o >= 32'h40 && addr_o < 32'h80) seen40 = 1;
            if (valid_o && first_k < 0) begin
                first_k = k;
                first_a = addr_o;
            end
            tick();
        end
        checks++;
        if (first_a !== 32'h80 || first_k != 1) begin
            errors++;
            $display("FAIL djump_first: addr=%h at %0d required 00000080 at 1", first_a, first_k);
        end
        checks++;
        if (seen40) begin
            errors++;
            $display("FAIL djump_stale: got 0x40-stream instruction required none");
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] got [$];
        ready_i = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        jmp_i = 1'b1;
        jmp_addr_i = 32'h43;
        @(negedge clk);
        checks++;
        if (imem_en_o !== 1'b1 || imem_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL misal_iaddr: en=%b iaddr=%h required 1 00000040", imem_en_o, imem_addr_o);
        end
        tick();
        jmp_i = 1'b0;
        for (int k = 0; k < 10 && got.size() < 2; k++) begin
            @(negedge clk);
            if (valid_o) got.push_back(addr_o);
            tick();
        end
        checks++;
        if (got.size() != 2 || got[0] !== 32'h40 || got[1] !== 32'h44) begin
            errors++;
            $display("FAIL misal_seq: got %0d entries first %h required 00000040 00000044",
                     got.size(), got.size() > 0 ? got[0] : 32'hx);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] first_a = 32'hffff_ffff;
        bit          found = 0;
        ready_i = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        rstn_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || imem_en_o !== 1'b0) begin
            errors++;
            $display("FAIL mrst_drop: valid=%b en=%b required 0 0", valid_o, imem_en_o);
        end
        tick();
        rstn_i = 1'b1;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (valid_o) begin
                found = 1;
                first_a = addr_o;
            end
            tick();
        end
        checks++;
        if (!found || first_a !== BOOT) begin
            errors++;
            $display("FAIL mrst_restart: found=%b addr=%h required 1 %h", found, first_a, BOOT);
        end
    endtask

    task automatic test_random();
        int nxfer = 0;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            ready_i = ($urandom_range(0, 9) < 7);
            jmp_i = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) jmp_addr_i = 32'hffff_fff0 | 32'($urandom_range(0, 15));
            else                            jmp_addr_i = $urandom & 32'h0000_0fff;
            @(negedge clk);
            if (valid_o && ready_i) nxfer++;
            tick();
        end
        jmp_i = 1'b0;
        checks++;
        if (nxfer < 100) begin
            errors++;
            $display("FAIL rand_progress: got %0d transfers required at least 100", nxfer);
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_stall();
        test_jump();
        test_double_jump();
        test_misaligned();
        test_mid_reset();
        test_random();
        ready_i = 1'b1;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jedro_1_ifu.md
JEDRO_1_IFU -- requirements
Module: jedro_1_ifu

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4: prefetch buffer entries; power of two, at least 2.
REQ-003 clk_i  input  1  single core clock; all state updates on the rising edge.
REQ-004 rstn_i  input  1  reset; asynchronous, active-low.
REQ-005 imem_en_o  output  1  instruction memory read request, one word per cycle.
REQ-006 imem_addr_o  output  32  byte address of the request; bits [1:0] always 0.
REQ-007 imem_data_i  input  32  read data, valid exactly one cycle after imem_en_o was high.
REQ-008 jmp_i  input  1  redirect request from execute stage.
REQ-009 jmp_addr_i  input  32  redirect target.
REQ-010 instr_o  output  32  instruction word to decoder.
REQ-011 addr_o  output  32  byte address of instr_o.
REQ-012 valid_o  output  1  instr_o and addr_o are valid.
REQ-013 ready_i  input  1  decoder accepts; a transfer occurs when valid_o and ready_i are both high on a rising edge.

Function
REQ-014 The block SHALL keep a fetch PC, issue reads at the fetch PC, and increment the fetch PC by 4 per issued read, wrapping modulo 2^32.
REQ-015 The block SHALL assert imem_en_o only when (FIFO occupancy + in-flight reads) < FIFO_DEPTH, so the FIFO never overflows.
REQ-016 Each response SHALL be pushed into the FIFO with its address in the cycle it returns, unless it is killed.
REQ-017 valid_o SHALL be high whenever the FIFO is non-empty; instr_o and addr_o SHALL come from the FIFO head and stay stable while valid_o is high and ready_i is low.
REQ-018 At steady state with ready_i held high, the block SHALL deliver one instruction per cycle.
REQ-019 Latency from imem_en_o to the matching valid_o SHALL be 2 cycles: data returns at T+1, is registered into the FIFO, and is visible at T+2. There is no bypass.
REQ-020 FSM states:
  - IDLE: reset held, no requests.
  - RUN: fetching.
  - IDLE to RUN on the first clock edge after rstn_i deasserts.
  - There is no other exit from RUN.
REQ-021 When jmp_i is high in cycle T, the block SHALL:
  - issue imem_en_o at address {jmp_addr_i[31:2],2'b00} in cycle T, ignoring the credit limit because the FIFO is flushed;
  - set the fetch PC to target+4;
  - flush the FIFO at the end of T;
  - kill any response for a read issued before T.
REQ-022 Misaligned jmp_addr_i SHALL have bits [1:0] silently cleared.
REQ-023 If a transfer and jmp_i coincide in cycle T, the transfer SHALL count. Killing that instruction is the downstream stages' responsibility.
REQ-024 When jmp_i is high in consecutive cycles, the last target SHALL win, and all responses for earlier targets SHALL be killed.
REQ-025 A push and a pop in the same cycle SHALL leave occupancy unchanged.

Reset
REQ-026 While rstn_i is low, the outputs SHALL be:
  - valid_o=0, imem_en_o=0;
  - imem_addr_o=BOOT_ADDR;
  - instr_o=32'h0000_0000, addr_o=32'h0000_0000.
REQ-027 While rstn_i is low, internal state SHALL be: FIFO empty, in-flight count 0, fetch PC=BOOT_ADDR, FSM=IDLE.
REQ-028 Reset asserted mid-operation SHALL clear all state asynchronously. A memory response arriving in the cycle after reset release SHALL be ignored.

Structure
REQ-029 The shared package jedro_1_defines SHALL hold:
  - the default BOOT_ADDR;
  - the NOP encoding 32'h0000_0013 for downstream use;
  - the IFU FSM state enum.
REQ-030 The FIFO SHALL be the sub-module jedro_1_ifu_fifo, parameterised by DEPTH and WIDTH=64, carrying {addr,instr}, with synchronous flush.

Verification
REQ-031 Reset release with a ROM whose word n = n, ready_i=1 -> imem_en_o first high 1 cycle after rstn_i rises; valid_o first high 2 cycles later with addr_o=0, instr_o=0; then addr_o=4,8,12... one per cycle.
REQ-032 ready_i=0 from start -> exactly 4 reads issued (addr 0..12), then imem_en_o=0 and outputs stable; ready_i=1 -> 4 back-to-back transfers, fetch resumes at 16, no loss or duplicate.
REQ-033 FIFO holding 3 entries, one read in flight, jmp_i=1 with jmp_addr_i=0x40 -> no old-stream instruction after T; next valid_o has addr_o=0x40 at T+2, then 0x44.
REQ-034 jmp_i at T (0x40) and T+1 (0x80) -> no 0x40 instruction is ever delivered; the first delivered address is 0x80.
REQ-035 rstn_i low for 1 cycle mid-stream -> valid_o drops immediately; after release, fetch restarts at BOOT_ADDR and the first addr_o is 0.
REQ-036 jmp_addr_i=0x43 -> imem_addr_o=0x40, and the delivered addr_o sequence is 0x40, 0x44.
